swerv_trace_sink: RTL and testbench

//  Receiving end of the core retirement-trace interface (trace_pkt_t fields).

---
 rtl/swerv_trace_sink.sv | 156 +++++++++++++++
 tb/tb_swerv_trace_sink.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/swerv_trace_sink.sv
// Retirement-trace sink: packs up to 3 retired instructions per cycle, in slot order, into a FIFO.
// Latency: a record captured in cycle N is presented on rec_* in cycle N+1 at the earliest.
// Backpressure: the trace input is never stalled. A packet that does not fit is dropped whole and counted. rec_* holds while rec_ready is low.
//
// Ports:
//   clk, rst_l                 core clock, asynchronous active-low reset
//   trace_en                   capture enable; when low, input is ignored and not counted as a drop
//   trace_rv_i_*               retirement trace packet (3 slots, shared ecause/tval)
//   rec_valid/rec_ready        record handshake toward the trace encoder / trace RAM
//   rec_insn .. rec_slot       head record; all zero while empty
//   ovf, drop_cnt, ovf_clr     sticky drop flag, saturating drop counter, and their clear
module swerv_trace_sink #(
   parameter int DEPTH  = 16,
   parameter int DCNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              trace_en,
   input  logic [2:0]        trace_rv_i_valid_ip,
   input  logic [95:0]       trace_rv_i_insn_ip,
   input  logic [95:0]       trace_rv_i_address_ip,
   input  logic [2:0]        trace_rv_i_exception_ip,
   input  logic [4:0]        trace_rv_i_ecause_ip,
   input  logic [2:0]        trace_rv_i_interrupt_ip,
   input  logic [31:0]       trace_rv_i_tval_ip,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [31:0]       rec_insn,
   output logic [31:0]       rec_pc,
   output logic              rec_exc,
   output logic              rec_intr,
   output logic [4:0]        rec_ecause,
   output logic [31:0]       rec_tval,
   output logic [1:0]        rec_slot,
   output logic              ovf,
   input  logic              ovf_clr,
   output logic [DCNT_W-1:0] drop_cnt
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
      logic        exc;
      logic        intr;
      logic [4:0]  ecause;
      logic [31:0] tval;
      logic [1:0]  slot;
   } rec_t;

   rec_t          mem [DEPTH];
   rec_t          slot_rec [3];
   logic [1:0]    slot_off [3];
   rec_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   free;
   logic [1:0]    n;
   logic          cap;
   logic          fit;
   logic          push;
   logic          drop;
   logic          pop;

   always_comb begin
      n    = 2'(trace_rv_i_valid_ip[0]) + 2'(trace_rv_i_valid_ip[1]) + 2'(trace_rv_i_valid_ip[2]);
      // Free space is judged on the start-of-cycle count only; a same-cycle pop gives no credit.
      free = (AW+1)'(DEPTH) - count;
      cap  = trace_en & (|trace_rv_i_valid_ip);
      fit  = (AW+1)'(n) <= free;
      push = cap & fit;
      drop = cap & ~fit;
      pop  = rec_valid & rec_ready;

      // Each valid slot lands after the valid slots below it, so sparse packets leave no holes.
      slot_off[0] = 2'd0;
      slot_off[1] = 2'(trace_rv_i_valid_ip[0]);
      slot_off[2] = 2'(trace_rv_i_valid_ip[0]) + 2'(trace_rv_i_valid_ip[1]);

      for (int k = 0; k < 3; k++) begin
         slot_rec[k].insn   = trace_rv_i_insn_ip[32*k +: 32];
         slot_rec[k].pc     = trace_rv_i_address_ip[32*k +: 32];
         slot_rec[k].exc    = trace_rv_i_exception_ip[k];
         slot_rec[k].intr   = trace_rv_i_interrupt_ip[k];
         slot_rec[k].slot   = 2'(k);
         // Shared cause/tval only mean something for a trapping slot.
         if (trace_rv_i_exception_ip[k] | trace_rv_i_interrupt_ip[k]) begin
            slot_rec[k].ecause = trace_rv_i_ecause_ip;
            slot_rec[k].tval   = trace_rv_i_tval_ip;
         end else begin
            slot_rec[k].ecause = 5'd0;
            slot_rec[k].tval   = 32'd0;
         end
      end
   end

   // The storage array needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int k = 0; k < 3; k++) begin
            if (trace_rv_i_valid_ip[k]) begin
               mem[wr_ptr + AW'(slot_off[k])] <= slot_rec[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(n);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (push ? (AW+1)'(n) : '0) - (pop ? (AW+1)'(1) : '0);

         // A drop in the same cycle as a clear wins: the counter restarts at one.
         if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr) begin
               drop_cnt <= DCNT_W'(1);
            end else if (!(&drop_cnt)) begin
               drop_cnt <= drop_cnt + DCNT_W'(1);
            end
         end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   assign rec_valid  = (count != '0);
   assign head       = rec_valid ? mem[rd_ptr] : '0;
   assign rec_insn   = head.insn;
   assign rec_pc     = head.pc;
   assign rec_exc    = head.exc;
   assign rec_intr   = head.intr;
   assign rec_ecause = head.ecause;
   assign rec_tval   = head.tval;
   assign rec_slot   = head.slot;

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_l)
      count <= (AW+1)'(DEPTH));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_l)
      !rec_valid |=> $stable(rd_ptr));
   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_l)
      rec_valid && !rec_ready |=> rec_valid && $stable(head));
endmodule

// File: tb/tb_swerv_trace_sink.sv
module tb_swerv_trace_sink;
   logic        clk = 1'b0;
   logic        rst_l;
   logic        trace_en;
   logic [2:0]  trace_rv_i_valid_ip;
   logic [95:0] trace_rv_i_insn_ip;
   logic [95:0] trace_rv_i_address_ip;
   logic [2:0]  trace_rv_i_exception_ip;
   logic [4:0]  trace_rv_i_ecause_ip;
   logic [2:0]  trace_rv_i_interrupt_ip;
   logic [31:0] trace_rv_i_tval_ip;
   logic        rec_valid;
   logic        rec_ready;
   logic [31:0] rec_insn;
   logic [31:0] rec_pc;
   logic        rec_exc;
   logic        rec_intr;
   logic [4:0]  rec_ecause;
   logic [31:0] rec_tval;
   logic [1:0]  rec_slot;
   logic        ovf;
   logic        ovf_clr;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   swerv_trace_sink #(.DEPTH(16), .DCNT_W(16)) dut (
      .clk(clk), .rst_l(rst_l), .trace_en(trace_en),
      .trace_rv_i_valid_ip(trace_rv_i_valid_ip),
      .trace_rv_i_insn_ip(trace_rv_i_insn_ip),
      .trace_rv_i_address_ip(trace_rv_i_address_ip),
      .trace_rv_i_exception_ip(trace_rv_i_exception_ip),
      .trace_rv_i_ecause_ip(trace_rv_i_ecause_ip),
      .trace_rv_i_interrupt_ip(trace_rv_i_interrupt_ip),
      .trace_rv_i_tval_ip(trace_rv_i_tval_ip),
      .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_insn(rec_insn), .rec_pc(rec_pc), .rec_exc(rec_exc), .rec_intr(rec_intr),
      .rec_ecause(rec_ecause), .rec_tval(rec_tval), .rec_slot(rec_slot),
      .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic [31:0] insn;
      logic [31:0] pc;
      logic        exc;
      logic        intr;
      logic [4:0]  ecause;
      logic [31:0] tval;
      logic [1:0]  slot;
   } mrec_t;

   // Reference: an unbounded queue of records clipped to 16 by the whole-packet fit rule.
   mrec_t q[$];
   logic  m_ovf  = 1'b0;
   int    m_drop = 0;
   int    total  = 0;
   int    bad    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      check("rec_valid", {63'd0, rec_valid}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
         check("rec_insn", rec_insn, q[0].insn);
         check("rec_pc", rec_pc, q[0].pc);
         check("rec_flags", {rec_exc, rec_intr, rec_slot}, {q[0].exc, q[0].intr, q[0].slot});
         check("rec_ecause", rec_ecause, q[0].ecause);
         check("rec_tval", rec_tval, q[0].tval);
      end else begin
         check("idle_zero_a", {rec_insn, rec_pc}, 64'd0);
         check("idle_zero_b", {rec_exc, rec_intr, rec_ecause, rec_tval, rec_slot}, 64'd0);
      end
      check("ovf", ovf, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
   endtask

   // One clock: check what the DUT shows, drive a packet, advance the model, clock it in.
   task automatic step(input logic en, input logic [2:0] v, input logic [95:0] insn,
                       input logic [95:0] pc, input logic [2:0] exc, input logic [2:0] intr,
                       input logic [4:0] ec, input logic [31:0] tv, input logic rdy,
                       input logic clr);
      int    free;
      mrec_t r;
      check_outputs();
      trace_en                = en;
      trace_rv_i_valid_ip     = v;
      trace_rv_i_insn_ip      = insn;
      trace_rv_i_address_ip   = pc;
      trace_rv_i_exception_ip = exc;
      trace_rv_i_interrupt_ip = intr;
      trace_rv_i_ecause_ip    = ec;
      trace_rv_i_tval_ip      = tv;
      rec_ready               = rdy;
      ovf_clr                 = clr;
      free = 16 - q.size();
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (en && v != 3'b000 && $countones(v) > free) begin
         m_ovf  = 1'b1;
         m_drop = clr ? 1 : (m_drop == 65535 ? m_drop : m_drop + 1);
      end else begin
         if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
         end
         if (en) begin
            for (int k = 0; k < 3; k++) begin
               if (v[k]) begin
                  r.insn   = insn[32*k +: 32];
                  r.pc     = pc[32*k +: 32];
                  r.exc    = exc[k];
                  r.intr   = intr[k];
                  r.slot   = 2'(k);
                  r.ecause = (exc[k] | intr[k]) ? ec : 5'd0;
                  r.tval   = (exc[k] | intr[k]) ? tv : 32'd0;
                  q.push_back(r);
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy, input logic clr);
      step(1'b1, 3'b000, 96'd0, 96'd0, 3'b000, 3'b000, 5'd0, 32'd0, rdy, clr);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1, 1'b0);
      check("drained", {63'd0, rec_valid}, 64'd0);
   endtask

   function automatic logic [95:0] rnd96();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [31:0] base;
      logic [95:0] pcs;
      rst_l = 1'b0;
      trace_en = 1'b0; trace_rv_i_valid_ip = '0; trace_rv_i_insn_ip = '0;
      trace_rv_i_address_ip = '0; trace_rv_i_exception_ip = '0; trace_rv_i_ecause_ip = '0;
      trace_rv_i_interrupt_ip = '0; trace_rv_i_tval_ip = '0; rec_ready = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_valid", {63'd0, rec_valid}, 64'd0);
      check("reset_ovf_cnt", {ovf, drop_cnt}, 64'd0);
      rst_l = 1'b1;
      @(negedge clk);

      // Single packet, slot 0.
      step(1'b1, 3'b001, {64'd0, 32'h0000_0013}, {64'd0, 32'h8000_0000}, 3'b000, 3'b000,
           5'd0, 32'd0, 1'b1, 1'b0);
      check("p1_pc", rec_pc, 32'h8000_0000);
      check("p1_slot", rec_slot, 2'd0);
      idle(1'b1, 1'b0);
      check("p1_empty", {63'd0, rec_valid}, 64'd0);

      // Sparse packet: slots 0 and 2 only.
      step(1'b1, 3'b101, rnd96(), {32'h108, 32'h104, 32'h100}, 3'b000, 3'b000,
           5'd0, 32'd0, 1'b1, 1'b0);
      check("sp_pc0", rec_pc, 32'h100);
      idle(1'b1, 1'b0);
      check("sp_pc2", rec_pc, 32'h108);
      check("sp_slot2", rec_slot, 2'd2);
      idle(1'b1, 1'b0);
      check("sp_empty", {63'd0, rec_valid}, 64'd0);

      // Exception record, then a plain record whose shared cause/tval must be hidden.
      step(1'b1, 3'b001, rnd96(), {64'd0, 32'h200}, 3'b001, 3'b000, 5'd2, 32'hDEAD_BEEF,
           1'b0, 1'b0);
      check("exc_flag", rec_exc, 1'b1);
      check("exc_cause", rec_ecause, 5'd2);
      check("exc_tval", rec_tval, 32'hDEAD_BEEF);
      idle(1'b1, 1'b0);
      step(1'b1, 3'b001, rnd96(), {64'd0, 32'h204}, 3'b000, 3'b000, 5'd7, 32'h1234_5678,
           1'b0, 1'b0);
      check("plain_cause_tval", {rec_ecause, rec_tval}, 64'd0);
      drain();

      // Overflow with the consumer stalled.
      for (int p = 0; p < 5; p++)
         step(1'b1, 3'b111, rnd96(), rnd96(), 3'b000, 3'b000, 5'd0, 32'd0, 1'b0, 1'b0);
      step(1'b1, 3'b111, rnd96(), rnd96(), 3'b000, 3'b000, 5'd0, 32'd0, 1'b0, 1'b0);
      check("ovf_first", {ovf, drop_cnt}, {47'd0, 1'b1, 16'd1});
      step(1'b1, 3'b001, rnd96(), rnd96(), 3'b000, 3'b000, 5'd0, 32'd0, 1'b0, 1'b0);
      // Full with a pop: no same-cycle credit, so the 1-wide packet is dropped.
      step(1'b1, 3'b001, rnd96(), rnd96(), 3'b000, 3'b000, 5'd0, 32'd0, 1'b1, 1'b0);
      check("full_pop_drop", drop_cnt, 16'd2);
      step(1'b1, 3'b111, rnd96(), rnd96(), 3'b000, 3'b000, 5'd0, 32'd0, 1'b0, 1'b1);
      check("clr_vs_drop", {ovf, drop_cnt}, {47'd0, 1'b1, 16'd1});
      idle(1'b0, 1'b1);
      check("clr_only", {ovf, drop_cnt}, 64'd0);
      drain();

      // Random traffic with stalls and pointer wrap; asynchronous reset mid-stream.
      base = 32'h4000_0000;
      for (int i = 0; i < 400; i++) begin
         pcs  = {base + 32'd8, base + 32'd4, base};
         base = base + 32'd12;
         step($urandom_range(0, 9) != 0, 3'($urandom), rnd96(), pcs,
              3'($urandom) & 3'($urandom), 3'($urandom) & 3'($urandom) & 3'($urandom),
              5'($urandom), $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
         if (i == 200) begin
            #2 rst_l = 1'b0;
            #1 check("async_rst_valid", {63'd0, rec_valid}, 64'd0);
            check("async_rst_ovf", {ovf, drop_cnt}, 64'd0);
            q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            @(negedge clk);
            rst_l = 1'b1;
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
